dispatch_ctrl: RTL and testbench

//  Dispatch scheduler between decode and the issue queues. Takes one decoded uop per cycle
//  (valid/queue/priority from decode o_ctrl, branch flag from o_en_j) and buffers it in a
//  2-entry skid FIFO. Routes the head uop to the MEM or ALU issue queue with a valid/ready

---
 rtl/dispatch_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_dispatch_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_ctrl.sv
// Dispatch scheduler: 2-entry skid buffer between decode and the MEM/ALU issue queues,
// with branch-tag stamping and unresolved-branch throttling.
// Optional feature macro: DISPATCH_ILLEGAL_TRAP_EN (sticky o_illegal trap and freeze on an illegal head).
module dispatch_ctrl #(
  parameter int WIDTH_BRM = 6,
  parameter int W_UOP     = 57,
  parameter int MAX_BR    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [1:0]           i_queue,
  input  logic [1:0]           i_pry,
  input  logic                 i_en_j,
  input  logic [W_UOP-1:0]     i_uop,
  output logic                 o_ready,
  output logic                 o_memq_valid,
  input  logic                 i_memq_ready,
  output logic                 o_aluq_valid,
  input  logic                 i_aluq_ready,
  output logic [W_UOP-1:0]     o_uop,
  output logic [1:0]           o_pry,
  output logic [WIDTH_BRM-1:0] o_brtag,
  input  logic                 i_br_resolve,
  input  logic                 i_flush,
  output logic                 o_br_full
`ifdef DISPATCH_ILLEGAL_TRAP_EN
  ,
  output logic                 o_illegal
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [1:0]           Q_MEM   = 2'b01;
  localparam logic [1:0]           Q_ALU   = 2'b10;
  localparam logic [WIDTH_BRM-1:0] BR_ONE  = WIDTH_BRM'(1);
  localparam logic [WIDTH_BRM-1:0] BR_ZERO = WIDTH_BRM'(0);
  localparam logic [WIDTH_BRM-1:0] BR_MAX  = WIDTH_BRM'(MAX_BR);

  state_t               state_r, state_nx_s;

  // slot 0 is the head presented on the outputs; slot 1 is the skid entry
  logic [W_UOP-1:0]     s0_uop_r, s0_uop_nx_s;
  logic [1:0]           s0_pry_r, s0_pry_nx_s;
  logic [1:0]           s0_q_r,   s0_q_nx_s;
  logic [WIDTH_BRM-1:0] s0_tag_r, s0_tag_nx_s;
  logic [W_UOP-1:0]     s1_uop_r, s1_uop_nx_s;
  logic [1:0]           s1_pry_r, s1_pry_nx_s;
  logic [1:0]           s1_q_r,   s1_q_nx_s;
  logic [WIDTH_BRM-1:0] s1_tag_r, s1_tag_nx_s;

  logic [WIDTH_BRM-1:0] tag_r,   tag_nx_s;
  logic [WIDTH_BRM-1:0] outst_r, outst_nx_s;
  logic                 br_full_r;
  logic                 memq_valid_r, aluq_valid_r;
  logic                 memq_valid_nx_s, aluq_valid_nx_s;

  logic                 head_illegal_s;
  logic                 freeze_s;
  logic                 ready_s;
  logic                 accept_s;
  logic                 pop_s;
  logic                 br_inc_s;

`ifdef DISPATCH_ILLEGAL_TRAP_EN
  logic                 illegal_r, illegal_nx_s;
`endif

  assign head_illegal_s = (state_r != ST_EMPTY) & (s0_q_r != Q_MEM) & (s0_q_r != Q_ALU);

`ifdef DISPATCH_ILLEGAL_TRAP_EN
  // an illegal head freezes dispatch from the cycle it appears until flush or reset
  assign freeze_s = illegal_r | head_illegal_s;
  assign pop_s    = (memq_valid_r & i_memq_ready) | (aluq_valid_r & i_aluq_ready);
`else
  // an illegal head is discarded in one cycle without offering it to any queue
  assign freeze_s = 1'b0;
  assign pop_s    = (memq_valid_r & i_memq_ready) | (aluq_valid_r & i_aluq_ready) | head_illegal_s;
`endif

  assign ready_s  = (state_r != ST_TWO) & ~(i_en_j & br_full_r) & ~i_flush & ~freeze_s;
  assign accept_s = i_valid & ready_s;
  assign br_inc_s = accept_s & i_en_j;

  assign o_ready      = ready_s;
  assign o_memq_valid = memq_valid_r;
  assign o_aluq_valid = aluq_valid_r;
  assign o_uop        = s0_uop_r;
  assign o_pry        = s0_pry_r;
  assign o_brtag      = s0_tag_r;
  assign o_br_full    = br_full_r;
`ifdef DISPATCH_ILLEGAL_TRAP_EN
  assign o_illegal    = illegal_r;
`endif

  // next-state, buffer, tag and outstanding-branch computation
  always_comb begin
    state_nx_s  = state_r;
    s0_uop_nx_s = s0_uop_r;
    s0_pry_nx_s = s0_pry_r;
    s0_q_nx_s   = s0_q_r;
    s0_tag_nx_s = s0_tag_r;
    s1_uop_nx_s = s1_uop_r;
    s1_pry_nx_s = s1_pry_r;
    s1_q_nx_s   = s1_q_r;
    s1_tag_nx_s = s1_tag_r;
    tag_nx_s    = tag_r;
    outst_nx_s  = outst_r;
`ifdef DISPATCH_ILLEGAL_TRAP_EN
    illegal_nx_s = illegal_r;
`endif

    if (i_flush) begin
      // payload slots keep stale data; nothing is valid once the state is EMPTY
      state_nx_s = ST_EMPTY;
      outst_nx_s = BR_ZERO;
`ifdef DISPATCH_ILLEGAL_TRAP_EN
      illegal_nx_s = 1'b0;
`endif
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            s0_uop_nx_s = i_uop;
            s0_pry_nx_s = i_pry;
            s0_q_nx_s   = i_queue;
            s0_tag_nx_s = tag_r;
            state_nx_s  = ST_ONE;
          end else begin
            state_nx_s  = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s & pop_s) begin
            s0_uop_nx_s = i_uop;
            s0_pry_nx_s = i_pry;
            s0_q_nx_s   = i_queue;
            s0_tag_nx_s = tag_r;
            state_nx_s  = ST_ONE;
          end else if (accept_s) begin
            s1_uop_nx_s = i_uop;
            s1_pry_nx_s = i_pry;
            s1_q_nx_s   = i_queue;
            s1_tag_nx_s = tag_r;
            state_nx_s  = ST_TWO;
          end else if (pop_s) begin
            state_nx_s  = ST_EMPTY;
          end else begin
            state_nx_s  = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            s0_uop_nx_s = s1_uop_r;
            s0_pry_nx_s = s1_pry_r;
            s0_q_nx_s   = s1_q_r;
            s0_tag_nx_s = s1_tag_r;
            state_nx_s  = ST_ONE;
          end else begin
            state_nx_s  = ST_TWO;
          end
        end
        default: begin
          state_nx_s = ST_EMPTY;
        end
      endcase

      if (br_inc_s) begin
        tag_nx_s = tag_r + BR_ONE;
      end else begin
        tag_nx_s = tag_r;
      end

      // a same-cycle allocate and resolve cancel; resolve saturates at zero
      if (br_inc_s & i_br_resolve) begin
        outst_nx_s = outst_r;
      end else if (br_inc_s) begin
        outst_nx_s = outst_r + BR_ONE;
      end else if (i_br_resolve & (outst_r != BR_ZERO)) begin
        outst_nx_s = outst_r - BR_ONE;
      end else begin
        outst_nx_s = outst_r;
      end

`ifdef DISPATCH_ILLEGAL_TRAP_EN
      illegal_nx_s = illegal_r | head_illegal_s;
`endif
    end

    memq_valid_nx_s = (state_nx_s != ST_EMPTY) & (s0_q_nx_s == Q_MEM);
    aluq_valid_nx_s = (state_nx_s != ST_EMPTY) & (s0_q_nx_s == Q_ALU);
  end

  // state and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_EMPTY;
      s0_uop_r     <= {W_UOP{1'b0}};
      s0_pry_r     <= 2'b00;
      s0_q_r       <= 2'b00;
      s0_tag_r     <= BR_ZERO;
      s1_uop_r     <= {W_UOP{1'b0}};
      s1_pry_r     <= 2'b00;
      s1_q_r       <= 2'b00;
      s1_tag_r     <= BR_ZERO;
      tag_r        <= BR_ZERO;
      outst_r      <= BR_ZERO;
      br_full_r    <= 1'b0;
      memq_valid_r <= 1'b0;
      aluq_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      s0_uop_r     <= s0_uop_nx_s;
      s0_pry_r     <= s0_pry_nx_s;
      s0_q_r       <= s0_q_nx_s;
      s0_tag_r     <= s0_tag_nx_s;
      s1_uop_r     <= s1_uop_nx_s;
      s1_pry_r     <= s1_pry_nx_s;
      s1_q_r       <= s1_q_nx_s;
      s1_tag_r     <= s1_tag_nx_s;
      tag_r        <= tag_nx_s;
      outst_r      <= outst_nx_s;
      br_full_r    <= (outst_nx_s == BR_MAX);
      memq_valid_r <= memq_valid_nx_s;
      aluq_valid_r <= aluq_valid_nx_s;
    end
  end

`ifdef DISPATCH_ILLEGAL_TRAP_EN
  // sticky illegal-head trap flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= illegal_nx_s;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Randomized self-checking bench for dispatch_ctrl against a queue-based reference model.
module tb_dispatch_ctrl;

  localparam int WIDTH_BRM = 6;
  localparam int W_UOP     = 57;
  localparam int MAX_BR    = 4;

  typedef struct packed {
    logic [W_UOP-1:0]     uop;
    logic [1:0]           pry;
    logic [1:0]           q;
    logic [WIDTH_BRM-1:0] tag;
  } ent_t;

  logic                 clk;
  logic                 rst_n;
  logic                 valid, en_j, memq_ready, aluq_ready, br_resolve, flush;
  logic [1:0]           queue, pry;
  logic [W_UOP-1:0]     uop;
  logic                 ready, memq_valid, aluq_valid, br_full;
  logic [W_UOP-1:0]     uop_o;
  logic [1:0]           pry_o;
  logic [WIDTH_BRM-1:0] brtag_o;
`ifdef DISPATCH_ILLEGAL_TRAP_EN
  logic                 illegal_o;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  ent_t mq[$];
  int   tag_m = 0;
  int   out_m = 0;
  bit   ill_m = 1'b0;

  dispatch_ctrl #(.WIDTH_BRM(WIDTH_BRM), .W_UOP(W_UOP), .MAX_BR(MAX_BR)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(valid), .i_queue(queue), .i_pry(pry), .i_en_j(en_j), .i_uop(uop),
    .o_ready(ready),
    .o_memq_valid(memq_valid), .i_memq_ready(memq_ready),
    .o_aluq_valid(aluq_valid), .i_aluq_ready(aluq_ready),
    .o_uop(uop_o), .o_pry(pry_o), .o_brtag(brtag_o),
    .i_br_resolve(br_resolve), .i_flush(flush), .o_br_full(br_full)
`ifdef DISPATCH_ILLEGAL_TRAP_EN
    , .o_illegal(illegal_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // one cycle: drive at negedge, compare at negedge+1, advance model at posedge
  task automatic step(input logic v, input logic [1:0] q, input logic [1:0] p, input logic j,
                      input logic [W_UOP-1:0] u, input logic mr, input logic ar,
                      input logic res, input logic fl);
    int   sz;
    ent_t h;
    bit   hill, frz, ev_mem, ev_alu, full, rdy, acc, pop;
    @(negedge clk);
    valid = v; queue = q; pry = p; en_j = j; uop = u;
    memq_ready = mr; aluq_ready = ar; br_resolve = res; flush = fl;
    #1;
    sz     = mq.size();
    h      = (sz > 0) ? mq[0] : '0;
    hill   = (sz > 0) && (h.q != 2'b01) && (h.q != 2'b10);
`ifdef DISPATCH_ILLEGAL_TRAP_EN
    frz    = ill_m || hill;
`else
    frz    = 1'b0;
`endif
    ev_mem = (sz > 0) && (h.q == 2'b01);
    ev_alu = (sz > 0) && (h.q == 2'b10);
    full   = (out_m == MAX_BR);
    rdy    = (sz < 2) && !(j && full) && !fl && !frz;
    chk("ready", 64'(ready), 64'(rdy));
    chk("memq_valid", 64'(memq_valid), 64'(ev_mem));
    chk("aluq_valid", 64'(aluq_valid), 64'(ev_alu));
    chk("br_full", 64'(br_full), 64'(full));
`ifdef DISPATCH_ILLEGAL_TRAP_EN
    chk("illegal", 64'(illegal_o), 64'(ill_m));
`endif
    if (sz > 0) begin
      chk("uop", 64'(uop_o), 64'(h.uop));
      chk("pry", 64'(pry_o), 64'(h.pry));
      chk("brtag", 64'(brtag_o), 64'(h.tag));
    end
    acc = v && rdy;
`ifdef DISPATCH_ILLEGAL_TRAP_EN
    pop = (ev_mem && mr) || (ev_alu && ar);
`else
    pop = (ev_mem && mr) || (ev_alu && ar) || hill;
`endif
    @(posedge clk);
    if (fl) begin
      mq.delete();
      out_m = 0;
      ill_m = 1'b0;
    end else begin
`ifdef DISPATCH_ILLEGAL_TRAP_EN
      if (hill) ill_m = 1'b1;
`endif
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{uop: u, pry: p, q: q, tag: WIDTH_BRM'(tag_m)});
      if (acc && j && !res) out_m = out_m + 1;
      else if (!(acc && j) && res && out_m > 0) out_m = out_m - 1;
      if (acc && j) tag_m = (tag_m + 1) % (1 << WIDTH_BRM);
    end
  endtask

  function automatic logic [W_UOP-1:0] rnd_uop();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W_UOP-1:0];
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b10, 2'b00, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0; queue = 2'b00; pry = 2'b00; en_j = 1'b0; uop = '0;
    memq_ready = 1'b0; aluq_ready = 1'b0; br_resolve = 1'b0; flush = 1'b0;
    #1;
    chk("rst_memq_valid", 64'(memq_valid), 64'd0);
    chk("rst_aluq_valid", 64'(aluq_valid), 64'd0);
    chk("rst_uop", 64'(uop_o), 64'd0);
    chk("rst_pry", 64'(pry_o), 64'd0);
    chk("rst_brtag", 64'(brtag_o), 64'd0);
    chk("rst_br_full", 64'(br_full), 64'd0);
    mq.delete();
    tag_m = 0;
    out_m = 0;
    ill_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
  endtask

  initial begin
    do_reset();

    // three ALU uops back-to-back with the queue always ready
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 2'(i), 1'b0, rnd_uop(), 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // MEM head stalled while two more uops arrive, then drain in order
    step(1'b1, 2'b01, 2'd1, 1'b0, 57'h0AAAA, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b10, 2'd2, 1'b0, 57'h0BBBB, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b01, 2'd3, 1'b0, 57'h0CCCC, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 2'd0, 1'b0, 57'h0DDDD, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // fill the branch budget, stall a branch, accept a non-branch, then resolve
    for (int i = 0; i < 4; i++) step(1'b1, 2'b10, 2'd0, 1'b1, rnd_uop(), 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b10, 2'd0, 1'b1, rnd_uop(), 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b10, 2'd1, 1'b0, rnd_uop(), 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b10, 2'd0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 2'b10, 2'd0, 1'b1, rnd_uop(), 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // flush with two buffered uops, outstanding branches and a same-cycle valid uop
    step(1'b1, 2'b01, 2'd0, 1'b0, rnd_uop(), 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'b01, 2'd0, 1'b0, rnd_uop(), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 2'd0, 1'b0, rnd_uop(), 1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);

    // illegal queue code at the head
    step(1'b1, 2'b00, 2'd2, 1'b0, rnd_uop(), 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 2'b10, 2'd0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);

    // randomized traffic; long enough to wrap the branch tag several times
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] q;
      q = ($urandom_range(0, 19) == 0) ? 2'(($urandom_range(0, 1) == 0) ? 0 : 3)
                                       : 2'($urandom_range(1, 2));
      step(($urandom_range(0, 9) < 7), q, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 4),
           rnd_uop(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 39) == 0));
      if (n == 1500) begin
        @(negedge clk);
        #2;
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
